// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO signal bundle: the receiver/bus side drives strobes (master),
// the FIFO returns data and status (slave).
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  flush;
  logic                  overrun_clr;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overrun;
  logic                  lvl_irq;

  modport master (
    output wr_valid, wr_data, rd_en, flush, overrun_clr,
    input  rd_data, empty, full, count, overrun, lvl_irq
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, flush, overrun_clr,
    output rd_data, empty, full, count, overrun, lvl_irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word fall-through circular buffer with sticky
// overrun flag and registered fill-level interrupt.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESHOLD  = 8
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  uart_rx_fifo_if.slave fifo
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THR_C   = (DEPTH_LOG2+1)'(THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt, cnt_nxt;
  logic                  overrun_q, lvl_irq_q;
  logic                  pop_ok, push_ok, drop;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    pop_ok  = fifo.rd_en && (cnt != '0);
    push_ok = fifo.wr_valid && ((cnt != DEPTH_C) || pop_ok);
    drop    = fifo.wr_valid && !push_ok && !fifo.flush;
    cnt_nxt = cnt;
    if (fifo.flush)
      cnt_nxt = '0;
    else if (push_ok && !pop_ok)
      cnt_nxt = cnt + 1'b1;
    else if (pop_ok && !push_ok)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overrun_q <= 1'b0;
      lvl_irq_q <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      lvl_irq_q <= (cnt_nxt >= THR_C);
      if (fifo.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Set wins over clear when a drop coincides with overrun_clr.
      if (drop)
        overrun_q <= 1'b1;
      else if (fifo.overrun_clr)
        overrun_q <= 1'b0;
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt.
  always_ff @(posedge ACLK) begin
    if (push_ok && !fifo.flush)
      mem[wr_ptr] <= fifo.wr_data;
  end

  assign fifo.rd_data = mem[rd_ptr];
  assign fifo.empty   = (cnt == '0);
  assign fifo.full    = (cnt == DEPTH_C);
  assign fifo.count   = cnt;
  assign fifo.overrun = overrun_q;
  assign fifo.lvl_irq = lvl_irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: linear step sequence with immediate
// assertions against hand-computed expectations.
module tb_uart_rx_fifo;
  logic ACLK = 1'b0;
  logic ARESETn;
  int   n_assert = 0;
  int   n_fail   = 0;

  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4), .THRESHOLD(8)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .fifo    (bus.slave)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the staged strobes on one rising edge, then drop them.
  task automatic tick();
    @(posedge ACLK);
    #1;
    bus.wr_valid    = 1'b0;
    bus.rd_en       = 1'b0;
    bus.flush       = 1'b0;
    bus.overrun_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
  endtask

  initial begin
    ARESETn         = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = 8'h00;
    bus.rd_en       = 1'b0;
    bus.flush       = 1'b0;
    bus.overrun_clr = 1'b0;
    #1;
    chk("rst_count",   32'(bus.count),   32'd0);
    chk("rst_empty",   32'(bus.empty),   32'd1);
    chk("rst_full",    32'(bus.full),    32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_lvl_irq", 32'(bus.lvl_irq), 32'd0);
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Pop while empty is ignored
    bus.rd_en = 1'b1; tick();
    chk("empty_pop_count", 32'(bus.count), 32'd0);
    chk("empty_pop_empty", 32'(bus.empty), 32'd1);

    // Two pushes, two pops
    push(8'hA5);
    chk("t1_count1", 32'(bus.count),   32'd1);
    chk("t1_empty0", 32'(bus.empty),   32'd0);
    chk("t1_fwft",   32'(bus.rd_data), 32'hA5);
    push(8'h3C);
    chk("t1_count2", 32'(bus.count),   32'd2);
    chk("t1_rd0",    32'(bus.rd_data), 32'hA5);
    bus.rd_en = 1'b1; tick();
    chk("t1_count3", 32'(bus.count),   32'd1);
    chk("t1_rd1",    32'(bus.rd_data), 32'h3C);
    bus.rd_en = 1'b1; tick();
    chk("t1_count4", 32'(bus.count),   32'd0);
    chk("t1_empty1", 32'(bus.empty),   32'd1);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full",    32'(bus.full),    32'd1);
    chk("t2_count",   32'(bus.count),   32'd16);
    chk("t2_lvl",     32'(bus.lvl_irq), 32'd1);
    chk("t2_ovr_pre", 32'(bus.overrun), 32'd0);
    push(8'hFF);
    chk("t2_ovr",     32'(bus.overrun), 32'd1);
    chk("t2_count_o", 32'(bus.count),   32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_pop%0d", i), 32'(bus.rd_data), 32'(i));
      bus.rd_en = 1'b1; tick();
    end
    chk("t2_empty",    32'(bus.empty),   32'd1);
    chk("t2_lvl_end",  32'(bus.lvl_irq), 32'd0);
    chk("t2_ovr_hold", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1; tick();
    chk("t2_ovr_clr",  32'(bus.overrun), 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("t3_oldest", 32'(bus.rd_data), 32'h10);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h55; bus.rd_en = 1'b1; tick();
    chk("t3_count", 32'(bus.count),   32'd16);
    chk("t3_full",  32'(bus.full),    32'd1);
    chk("t3_ovr",   32'(bus.overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t3_pop%0d", i), 32'(bus.rd_data), 32'(8'h10 + i));
      bus.rd_en = 1'b1; tick();
    end
    chk("t3_last", 32'(bus.rd_data), 32'h55);
    bus.rd_en = 1'b1; tick();
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push and pop while empty; set-wins overrun
    bus.wr_valid = 1'b1; bus.wr_data = 8'h77; bus.rd_en = 1'b1; tick();
    chk("t4_count", 32'(bus.count),   32'd1);
    chk("t4_rd",    32'(bus.rd_data), 32'h77);
    for (int i = 0; i < 15; i++) push(8'(8'h80 + i));
    chk("t4_full", 32'(bus.full), 32'd1);
    bus.wr_valid = 1'b1; bus.wr_data = 8'hEE; bus.overrun_clr = 1'b1; tick();
    chk("t4_ovr_setwins", 32'(bus.overrun), 32'd1);
    chk("t4_rd_keep",     32'(bus.rd_data), 32'h77);
    bus.flush = 1'b1; tick();
    chk("t4_flush_count", 32'(bus.count),   32'd0);
    chk("t4_flush_ovr",   32'(bus.overrun), 32'd1);

    // Threshold interrupt and flush priority
    for (int i = 0; i < 7; i++) push(8'(i));
    chk("t5_lvl7", 32'(bus.lvl_irq), 32'd0);
    push(8'h07);
    chk("t5_count8", 32'(bus.count),   32'd8);
    chk("t5_lvl8",   32'(bus.lvl_irq), 32'd1);
    bus.rd_en = 1'b1; tick();
    chk("t5_count7", 32'(bus.count),   32'd7);
    chk("t5_lvl_lo", 32'(bus.lvl_irq), 32'd0);
    bus.flush = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h99; tick();
    chk("t5_flush_count", 32'(bus.count), 32'd0);
    chk("t5_flush_empty", 32'(bus.empty), 32'd1);

    // Reset mid-push, then pointer wrap
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    chk("t6_count5", 32'(bus.count), 32'd5);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h45;
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_rst_count", 32'(bus.count),   32'd0);
    chk("t6_rst_empty", 32'(bus.empty),   32'd1);
    chk("t6_rst_ovr",   32'(bus.overrun), 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    bus.wr_valid = 1'b0;
    chk("t6_post_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t6_wrap%0d", i), 32'(bus.rd_data), 32'(8'hC0 + i));
      bus.wr_valid = 1'b1; bus.wr_data = 8'(8'hC3 + i); bus.rd_en = 1'b1; tick();
    end
    chk("t6_wrap_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_tail%0d", i), 32'(bus.rd_data), 32'(8'hD4 + i));
      bus.rd_en = 1'b1; tick();
    end
    chk("t6_empty", 32'(bus.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of each stored entry.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, log2 of entry count (DEPTH = 2^DEPTH_LOG2 = 16).
REQ-003 SHALL have parameter THRESHOLD, default 8, fill level at or above which lvl_irq asserts; legal range 1..DEPTH.
REQ-004 SHALL have port ACLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port wr_valid  input  1  one-cycle push strobe, driven by the UART receiver's rx_done.
REQ-007 SHALL have port wr_data  input  DATA_WIDTH  receiver byte, sampled when wr_valid=1.
REQ-008 SHALL have port rd_en  input  1  pop strobe from the AXI-Lite RX-data read handshake.
REQ-009 SHALL have port rd_data  output  DATA_WIDTH  oldest entry (first-word fall-through).
REQ-010 SHALL have port flush  input  1  synchronous FIFO clear from a control-register bit.
REQ-011 SHALL have port overrun_clr  input  1  clears the sticky overrun flag.
REQ-012 SHALL have port empty  output  1  high when count=0.
REQ-013 SHALL have port full  output  1  high when count=DEPTH.
REQ-014 SHALL have port count  output  DEPTH_LOG2+1  current number of stored entries, 0..DEPTH.
REQ-015 SHALL have port overrun  output  1  sticky: a byte was dropped while full.
REQ-016 SHALL have port lvl_irq  output  1  registered, high when count>=THRESHOLD.

Function
REQ-017 SHALL store entries in a DEPTH-entry circular buffer with DEPTH_LOG2-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-018 SHALL drive rd_data combinationally from the entry at the read pointer; value is don't-care when empty=1 and SHALL NOT be relied on.
REQ-019 SHALL accept a push (write entry, advance write pointer) when wr_valid=1 and (full=0 or an accepted pop occurs the same cycle).
REQ-020 SHALL accept a pop (advance read pointer) when rd_en=1 and empty=0; rd_en while empty SHALL be ignored with no state change.
REQ-021 SHALL update count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; empty/full/count reflect the new value the cycle after the edge.
REQ-022 SHALL, on simultaneous push and pop while empty, accept the push, ignore the pop, and end with count=1.
REQ-023 SHALL, on simultaneous push and pop while full, accept both, keep count=DEPTH and full=1, and store the new byte in the freed slot.
REQ-024 SHALL, on wr_valid=1 while full with no accepted pop, discard wr_data, leave buffer state unchanged, and set overrun=1 on the next cycle.
REQ-025 SHALL hold overrun at 1 until overrun_clr=1; if an overrun event and overrun_clr coincide, overrun SHALL remain 1 (set wins).
REQ-026 SHALL, on flush=1, reset both pointers and count to 0 on that edge, with flush taking priority over any same-cycle push or pop; overrun SHALL be unaffected.
REQ-027 SHALL register lvl_irq from the post-update count, so it lags count by zero cycles relative to the same edge (both change on the same edge).
REQ-028 SHALL contain no latency between push and visibility: a byte pushed into an empty FIFO SHALL appear on rd_data, with empty=0, one cycle after the push edge.

Reset
REQ-029 SHALL, while ARESETn=0, force pointers=0, count=0, empty=1, full=0, overrun=0, lvl_irq=0 asynchronously; buffer contents need not be cleared.
REQ-030 SHALL, on reset assertion mid-operation, discard all stored entries; the first edge after deassertion behaves as from an empty FIFO.

Verification
REQ-031 SHALL verify: push 0xA5 then 0x3C into empty FIFO, then rd_en twice -> rd_data 0xA5 then 0x3C, count 1->2->1->0, empty=1 at end.
REQ-032 SHALL verify: 16 pushes of 0x00..0x0F -> full=1, count=16; 17th push 0xFF -> dropped, overrun=1; 16 pops return 0x00..0x0F in order.
REQ-033 SHALL verify: full FIFO with simultaneous push 0x55 and pop -> count stays 16, popped byte is oldest, 0x55 read last.
REQ-034 SHALL verify: empty FIFO with simultaneous push 0x77 and rd_en -> count=1, rd_data=0x77; then overrun_clr concurrent with overflow push -> overrun stays 1.
REQ-035 SHALL verify: 8 pushes -> lvl_irq=1 at count=8; one pop -> lvl_irq=0; flush with concurrent push -> count=0, empty=1.
REQ-036 SHALL verify: 5 pushes, ARESETn low for 1 cycle mid-push -> count=0, empty=1, overrun=0 immediately; 20 push/pop cycles after release exercise pointer wrap with data intact.
